// File: rtl/dispatch_ctrl_pkg.sv
// Shared types, RISC-V opcode constants and the issue-class decoder for the dispatch controller.
package dispatch_ctrl_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned OPC_W = 7;

    localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
    localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
    localparam logic [OPC_W-1:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;
    localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
    localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;

    // One queue entry: PC, instruction word and branch prediction (97 bits).
    typedef struct packed {
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] ins;
        logic            pred_jmp;
        logic [XLEN-1:0] pred_another;
    } ins_entry_t;

    typedef enum logic [1:0] {
        CLS_ROB = 2'd0,
        CLS_RS  = 2'd1,
        CLS_LSB = 2'd2
    } ins_class_e;

    typedef enum logic [1:0] {
        OCC_EMPTY   = 2'd0,
        OCC_PARTIAL = 2'd1,
        OCC_FULL    = 2'd2
    } occ_e;

    // Map an opcode to the downstream unit that must have room before issue.
    function automatic ins_class_e classify(input logic [OPC_W-1:0] opcode);
        ins_class_e cls;
        case (opcode)
            OPC_JALR, OPC_BRANCH, OPC_OPIMM, OPC_OP: cls = CLS_RS;
            OPC_LOAD, OPC_STORE:                     cls = CLS_LSB;
            default:                                 cls = CLS_ROB;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/dispatch_ctrl_ins_queue.sv
// Circular instruction queue: payload storage, head/tail pointers and occupancy.
module ins_queue
    import dispatch_ctrl_pkg::*;
#(
    parameter int unsigned QDEPTH = 2
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       push,
    input  logic       pop,
    input  logic       clear,
    input  ins_entry_t wr_entry,
    output ins_entry_t head_entry,
    output occ_e       occ
);

    localparam int unsigned PTR_W = $clog2(QDEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    ins_entry_t       mem_q [QDEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Pointer and count update; a flush zeroes everything and overrides push/pop.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (clear) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) tail_d = tail_q + PTR_W'(1);
            if (pop)  head_d = head_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Occupancy classification used for flow control.
    always_comb begin
        occ = OCC_PARTIAL;
        if (count_q == '0)                     occ = OCC_EMPTY;
        else if (count_q == CNT_W'(QDEPTH))    occ = OCC_FULL;
    end

    // Pointer/count registers.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload storage, deliberately not reset.
    always_ff @(posedge clk_in) begin
        if (push && !clear) mem_q[tail_q] <= wr_entry;
    end

    assign head_entry = mem_q[head_q];

endmodule

// File: rtl/dispatch_ctrl.sv
// Fetch-to-decode dispatch: queues fetched instructions and issues the head when downstream has room.
module dispatch_ctrl
    import dispatch_ctrl_pkg::*;
#(
    parameter int unsigned QDEPTH = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        if_valid,
    input  logic [31:0] if_addr,
    input  logic [31:0] if_ins,
    input  logic        if_pred_jmp,
    input  logic [31:0] if_pred_another,
    output logic        if_ready,
    input  logic        rs_full,
    input  logic        lsb_full,
    input  logic        rob_full,
    input  logic        rob_clear,
    output logic        dec_valid,
    output logic [31:0] dec_addr,
    output logic [31:0] dec_ins,
    output logic        dec_pred_jmp,
    output logic [31:0] dec_pred_another,
    output logic [31:0] stall_cnt,
    output logic [31:0] issue_cnt
);

    localparam int unsigned CNT_W = 32;

    ins_entry_t       wr_entry;
    ins_entry_t       head;
    occ_e             occ;
    ins_class_e       head_cls;
    logic             active;
    logic             nonempty;
    logic             can_issue;
    logic             pop;
    logic             push;
    logic             clear;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] issue_cnt_q, issue_cnt_d;

    assign wr_entry = '{addr: if_addr, ins: if_ins, pred_jmp: if_pred_jmp,
                        pred_another: if_pred_another};

    ins_queue #(.QDEPTH(QDEPTH)) u_queue (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .push       (push),
        .pop        (pop),
        .clear      (clear),
        .wr_entry   (wr_entry),
        .head_entry (head),
        .occ        (occ)
    );

    // Issue gating and fetch flow control; the head issues combinationally, no bypass from fetch.
    always_comb begin
        active    = rdy_in && !rob_clear && !rst_in;
        nonempty  = (occ != OCC_EMPTY);
        head_cls  = classify(head.ins[OPC_W-1:0]);
        can_issue = !rob_full
                 && !((head_cls == CLS_RS)  && rs_full)
                 && !((head_cls == CLS_LSB) && lsb_full);
        pop       = active && nonempty && can_issue;
        if_ready  = active && ((occ != OCC_FULL) || pop);
        push      = if_valid && if_ready;
        clear     = rdy_in && rob_clear && !rst_in;
    end

    // Stall and issue statistics; survive a flush, wrap naturally.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        issue_cnt_d = issue_cnt_q;
        if (active && nonempty && !can_issue) stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (pop)                              issue_cnt_d = issue_cnt_q + CNT_W'(1);
    end

    // Counter registers.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            stall_cnt_q <= '0;
            issue_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            issue_cnt_q <= issue_cnt_d;
        end
    end

    assign dec_valid        = pop;
    assign dec_addr         = head.addr;
    assign dec_ins          = head.ins;
    assign dec_pred_jmp     = head.pred_jmp;
    assign dec_pred_another = head.pred_another;
    assign stall_cnt        = stall_cnt_q;
    assign issue_cnt        = issue_cnt_q;

endmodule

// File: tb/tb_dispatch_ctrl.sv
// Self-checking bench for dispatch_ctrl: vector table plus randomized stream with an issue-order scoreboard.
module tb_dispatch_ctrl;

    localparam logic [31:0] ADD  = 32'h00B5_0533;
    localparam logic [31:0] LOAD = 32'h0002_A303;
    localparam logic [31:0] LUI  = 32'h1234_52B7;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, if_valid, if_pred_jmp, if_ready;
    logic [31:0] if_addr, if_ins, if_pred_another;
    logic        rs_full, lsb_full, rob_full, rob_clear;
    logic        dec_valid, dec_pred_jmp;
    logic [31:0] dec_addr, dec_ins, dec_pred_another, stall_cnt, issue_cnt;

    dispatch_ctrl #(.QDEPTH(2)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .if_valid(if_valid), .if_addr(if_addr), .if_ins(if_ins),
        .if_pred_jmp(if_pred_jmp), .if_pred_another(if_pred_another), .if_ready(if_ready),
        .rs_full(rs_full), .lsb_full(lsb_full), .rob_full(rob_full), .rob_clear(rob_clear),
        .dec_valid(dec_valid), .dec_addr(dec_addr), .dec_ins(dec_ins),
        .dec_pred_jmp(dec_pred_jmp), .dec_pred_another(dec_pred_another),
        .stall_cnt(stall_cnt), .issue_cnt(issue_cnt)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        bit          rst, rdy, vld;
        logic [31:0] addr, ins;
        bit          rs, lsb, rob, clr;
        bit          chk_cnt;
        bit          e_dv, e_rdy;
        logic [31:0] e_stall, e_issue;
    } vec_t;

    typedef struct {
        logic [31:0] addr, ins, pa;
        logic        pj;
    } sb_t;

    vec_t vecs[$];
    sb_t  sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    function automatic vec_t mk(bit rst, bit rdy, bit vld, logic [31:0] addr, logic [31:0] ins,
                                bit rs, bit lsb, bit rob, bit clr, bit chk,
                                bit e_dv, bit e_rdy, logic [31:0] e_stall, logic [31:0] e_issue);
        vec_t v;
        v.rst = rst; v.rdy = rdy; v.vld = vld; v.addr = addr; v.ins = ins;
        v.rs = rs; v.lsb = lsb; v.rob = rob; v.clr = clr; v.chk_cnt = chk;
        v.e_dv = e_dv; v.e_rdy = e_rdy; v.e_stall = e_stall; v.e_issue = e_issue;
        return v;
    endfunction

    function automatic int cls_of(logic [31:0] ins);
        case (ins[6:0])
            7'h33, 7'h13, 7'h63, 7'h67: return 1;
            7'h03, 7'h23:               return 2;
            default:                    return 0;
        endcase
    endfunction

    task automatic check32(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Drive one cycle at negedge, compare outputs #1 later, keep the issue scoreboard in step.
    task automatic apply(input vec_t v, input int idx);
        sb_t e;
        @(negedge clk_in);
        rst_in = v.rst; rdy_in = v.rdy; if_valid = v.vld;
        if_addr = v.addr; if_ins = v.ins;
        if_pred_jmp = v.addr[2]; if_pred_another = v.addr ^ 32'hA5A5_0000;
        rs_full = v.rs; lsb_full = v.lsb; rob_full = v.rob; rob_clear = v.clr;
        #1;
        check32($sformatf("v%0d dec_valid", idx), 32'(dec_valid), 32'(v.e_dv));
        check32($sformatf("v%0d if_ready", idx), 32'(if_ready), 32'(v.e_rdy));
        if (v.chk_cnt) begin
            check32($sformatf("v%0d stall_cnt", idx), stall_cnt, v.e_stall);
            check32($sformatf("v%0d issue_cnt", idx), issue_cnt, v.e_issue);
        end
        if (v.e_dv) begin
            if (sb.size() == 0) begin
                n_chk++;
                $display("FAIL v%0d scoreboard: issue expected but nothing queued", idx);
            end else begin
                e = sb.pop_front();
                check32($sformatf("v%0d dec_addr", idx), dec_addr, e.addr);
                check32($sformatf("v%0d dec_ins", idx), dec_ins, e.ins);
                check32($sformatf("v%0d dec_pred_jmp", idx), 32'(dec_pred_jmp), 32'(e.pj));
                check32($sformatf("v%0d dec_pred_another", idx), dec_pred_another, e.pa);
            end
        end
        if (v.rst || (v.rdy && v.clr)) sb.delete();
        if (v.vld && v.e_rdy) begin
            e.addr = v.addr; e.ins = v.ins; e.pj = v.addr[2]; e.pa = v.addr ^ 32'hA5A5_0000;
            sb.push_back(e);
        end
    endtask

    initial begin
        logic [31:0] pool [6];
        logic [31:0] m_stall, m_issue, pc;
        vec_t        v;
        int          hc;
        bit          act, can;

        //            rst rdy vld addr         ins   rs lsb rob clr chk dv rdy stall issue
        vecs.push_back(mk(1, 1, 0, 32'h00, ADD,  0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 32'h00, ADD,  0, 0, 0, 0, 1, 0, 0, 0, 0));
        // single op issues the cycle after it is pushed
        vecs.push_back(mk(0, 1, 1, 32'h00, ADD,  0, 0, 0, 0, 1, 0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 32'h00, ADD,  0, 0, 0, 0, 1, 1, 1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 32'h00, ADD,  0, 0, 0, 0, 1, 0, 1, 0, 1));
        // load blocked by lsb_full for 3 cycles, rs_full irrelevant
        vecs.push_back(mk(0, 1, 1, 32'h04, LOAD, 1, 1, 0, 0, 1, 0, 1, 0, 1));
        vecs.push_back(mk(0, 1, 0, 32'h04, LOAD, 1, 1, 0, 0, 1, 0, 1, 0, 1));
        vecs.push_back(mk(0, 1, 0, 32'h04, LOAD, 1, 1, 0, 0, 1, 0, 1, 1, 1));
        vecs.push_back(mk(0, 1, 0, 32'h04, LOAD, 1, 1, 0, 0, 1, 0, 1, 2, 1));
        vecs.push_back(mk(0, 1, 0, 32'h04, LOAD, 1, 0, 0, 0, 1, 1, 1, 3, 1));
        vecs.push_back(mk(0, 1, 0, 32'h04, LOAD, 0, 0, 0, 0, 1, 0, 1, 3, 2));
        // lui only cares about rob_full
        vecs.push_back(mk(0, 1, 1, 32'h08, LUI,  1, 1, 0, 0, 1, 0, 1, 3, 2));
        vecs.push_back(mk(0, 1, 0, 32'h08, LUI,  1, 1, 0, 0, 1, 1, 1, 3, 2));
        vecs.push_back(mk(0, 1, 1, 32'h0C, LUI,  1, 1, 0, 0, 1, 0, 1, 3, 3));
        vecs.push_back(mk(0, 1, 0, 32'h0C, LUI,  1, 1, 1, 0, 1, 0, 1, 3, 3));
        vecs.push_back(mk(0, 1, 0, 32'h0C, LUI,  0, 0, 0, 0, 1, 1, 1, 4, 3));
        vecs.push_back(mk(0, 1, 0, 32'h0C, LUI,  0, 0, 0, 0, 1, 0, 1, 4, 4));
        // fill to full, backpressure, then push+pop on a full queue
        vecs.push_back(mk(0, 1, 1, 32'h10, ADD,  0, 0, 1, 0, 1, 0, 1, 4, 4));
        vecs.push_back(mk(0, 1, 1, 32'h14, ADD,  0, 0, 1, 0, 1, 0, 1, 4, 4));
        vecs.push_back(mk(0, 1, 1, 32'h18, ADD,  0, 0, 1, 0, 1, 0, 0, 5, 4));
        vecs.push_back(mk(0, 1, 1, 32'h18, ADD,  0, 0, 0, 0, 1, 1, 1, 6, 4));
        vecs.push_back(mk(0, 1, 0, 32'h18, ADD,  0, 0, 0, 0, 1, 1, 1, 6, 5));
        vecs.push_back(mk(0, 1, 0, 32'h18, ADD,  0, 0, 0, 0, 1, 1, 1, 6, 6));
        vecs.push_back(mk(0, 1, 0, 32'h18, ADD,  0, 0, 0, 0, 1, 0, 1, 6, 7));
        // flush a full queue while fetch is valid
        vecs.push_back(mk(0, 1, 1, 32'h20, ADD,  0, 0, 1, 0, 1, 0, 1, 6, 7));
        vecs.push_back(mk(0, 1, 1, 32'h24, ADD,  0, 0, 1, 0, 1, 0, 1, 6, 7));
        vecs.push_back(mk(0, 1, 1, 32'h30, ADD,  0, 0, 0, 1, 1, 0, 0, 7, 7));
        vecs.push_back(mk(0, 1, 1, 32'h40, ADD,  0, 0, 0, 0, 1, 0, 1, 7, 7));
        vecs.push_back(mk(0, 1, 0, 32'h40, ADD,  0, 0, 0, 0, 1, 1, 1, 7, 7));
        vecs.push_back(mk(0, 1, 0, 32'h40, ADD,  0, 0, 0, 0, 1, 0, 1, 7, 8));
        // rdy_in low for 4 cycles freezes everything
        vecs.push_back(mk(0, 1, 1, 32'h50, ADD,  0, 0, 0, 0, 1, 0, 1, 7, 8));
        for (int k = 0; k < 4; k++)
            vecs.push_back(mk(0, 0, 1, 32'h54, ADD, 0, 0, 0, 0, 1, 0, 0, 7, 8));
        vecs.push_back(mk(0, 1, 0, 32'h54, ADD,  0, 0, 0, 0, 1, 1, 1, 7, 8));
        vecs.push_back(mk(0, 1, 0, 32'h54, ADD,  0, 0, 0, 0, 1, 0, 1, 7, 9));
        // reset wins over rob_clear and a valid fetch
        vecs.push_back(mk(1, 1, 1, 32'h60, ADD,  0, 0, 0, 1, 1, 0, 0, 7, 9));
        vecs.push_back(mk(0, 1, 0, 32'h60, ADD,  0, 0, 0, 0, 1, 0, 1, 0, 0));

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

        // Randomized stream: expectations from the occupancy/class model built on the scoreboard.
        pool[0] = ADD; pool[1] = LOAD; pool[2] = LUI;
        pool[3] = 32'h0062_A023; pool[4] = 32'h0000_0063; pool[5] = 32'h0000_006F;
        m_stall = 0; m_issue = 0; pc = 32'h100;
        for (int i = 0; i < 160; i++) begin
            v.rst = 0;
            v.rdy = ($urandom_range(0, 7) != 0);
            v.clr = (i < 150) && ($urandom_range(0, 19) == 0);
            v.vld = (i < 150) && ($urandom_range(0, 3) != 0);
            v.addr = pc;
            v.ins = pool[$urandom_range(0, 5)];
            v.rs  = (i < 150) && ($urandom_range(0, 2) == 0);
            v.lsb = (i < 150) && ($urandom_range(0, 2) == 0);
            v.rob = (i < 150) && ($urandom_range(0, 4) == 0);
            hc  = (sb.size() != 0) ? cls_of(sb[0].ins) : 0;
            act = v.rdy && !v.clr;
            can = !v.rob && !(hc == 1 && v.rs) && !(hc == 2 && v.lsb);
            v.e_dv    = act && (sb.size() != 0) && can;
            v.e_rdy   = act && ((sb.size() < 2) || v.e_dv);
            v.chk_cnt = 1;
            v.e_stall = m_stall;
            v.e_issue = m_issue;
            if (act && (sb.size() != 0) && !can) m_stall = m_stall + 32'd1;
            if (v.e_dv) m_issue = m_issue + 32'd1;
            if (v.vld && v.e_rdy) pc = pc + 32'd4;
            apply(v, 1000 + i);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
